// File: rtl/btn_evt_pkg.sv
// Shared types and helpers for the button gesture decoder.
// Gesture states and the sizing rule for the millisecond counter.
package btn_evt_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        PRESSED1    = 3'd1,
        WAIT_SECOND = 3'd2,
        PRESSED2    = 3'd3,
        LONG_HELD   = 3'd4
    } btn_state_t;

    // Counter must hold the largest gesture window, in ticks.
    function automatic int ms_cnt_width(input int long_ms, input int dbl_ms, input int rpt_ms);
        int m;
        m = long_ms;
        if (dbl_ms > m) begin
            m = dbl_ms;
        end else begin
            m = m;
        end
        if (rpt_ms > m) begin
            m = rpt_ms;
        end else begin
            m = m;
        end
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/button_event_decoder_ms_tick.sv
// ms_tick_gen: divide-by-DIV prescaler with a synchronous clear.
// tick is registered and is high in the cycle the count sits at DIV-1.
module ms_tick_gen #(
    parameter int DIV = 50_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;
    logic          tick_q;

    // Next prescaler count: clear wins, otherwise wrap at DIV-1.
    always_comb begin
        if (clear) begin
            cnt_d = {PW{1'b0}};
        end else if (cnt_q == LAST) begin
            cnt_d = {PW{1'b0}};
        end else begin
            cnt_d = cnt_q + PW'(1'b1);
        end
    end

    // Count register and registered tick flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= {PW{1'b0}};
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == LAST);
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into short/long/double-click pulses and a held level.
// Optional auto-repeat while long-held is enabled by defining BTN_AUTOREPEAT_EN.
module button_event_decoder
    import btn_evt_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 1000,
    parameter int LONG_MS   = 800,
    parameter int DBL_MS    = 250,
    parameter int REPEAT_MS = 100
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_in,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic repeat_pulse,
    output logic held
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = ms_cnt_width(LONG_MS, DBL_MS, REPEAT_MS);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_MS - 1);
    localparam logic [CW-1:0] DBL_LAST  = CW'(DBL_MS - 1);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CW-1:0] RPT_LAST  = CW'(REPEAT_MS - 1);
`endif

    btn_state_t    state_q;
    btn_state_t    state_d;
    logic [CW-1:0] ms_cnt_q;
    logic [CW-1:0] ms_cnt_d;
    logic          btn_q;
    logic          rise_s;
    logic          fall_s;
    logic          tick_s;
    logic          clear_s;
    logic          restart_s;
    logic          short_d, long_d, dbl_d;
    logic          short_q, long_q, dbl_q, held_q;
`ifdef BTN_AUTOREPEAT_EN
    logic          rpt_d;
    logic          rpt_q;
`endif

    assign rise_s = btn_in & ~btn_q;
    assign fall_s = ~btn_in & btn_q;

    ms_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear_s),
        .tick    (tick_s)
    );

    // Next-state and event decision; edges take priority over same-cycle timeouts.
    always_comb begin
        state_d = state_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        dbl_d   = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        rpt_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (rise_s) begin
                    state_d = PRESSED1;
                end else begin
                    state_d = IDLE;
                end
            end
            PRESSED1: begin
                if (fall_s) begin
                    state_d = WAIT_SECOND;
                end else if (tick_s && (ms_cnt_q == LONG_LAST)) begin
                    state_d = LONG_HELD;
                    long_d  = 1'b1;
                end else begin
                    state_d = PRESSED1;
                end
            end
            WAIT_SECOND: begin
                if (rise_s) begin
                    state_d = PRESSED2;
                    dbl_d   = 1'b1;
                end else if (tick_s && (ms_cnt_q == DBL_LAST)) begin
                    state_d = IDLE;
                    short_d = 1'b1;
                end else begin
                    state_d = WAIT_SECOND;
                end
            end
            PRESSED2: begin
                if (fall_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = PRESSED2;
                end
            end
            LONG_HELD: begin
                if (fall_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = LONG_HELD;
`ifdef BTN_AUTOREPEAT_EN
                    rpt_d   = tick_s && (ms_cnt_q == RPT_LAST);
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign clear_s = (state_d != state_q);
`ifdef BTN_AUTOREPEAT_EN
    assign restart_s = clear_s | rpt_d;
`else
    assign restart_s = clear_s;
`endif

    // Millisecond counter restarts on any transition so windows are exact.
    always_comb begin
        if (restart_s) begin
            ms_cnt_d = {CW{1'b0}};
        end else if (tick_s && (ms_cnt_q != CNT_MAX)) begin
            ms_cnt_d = ms_cnt_q + CW'(1'b1);
        end else begin
            ms_cnt_d = ms_cnt_q;
        end
    end

    // FSM state, counter and registered outputs; btn_q resets high to mask a held button.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ms_cnt_q <= {CW{1'b0}};
            btn_q    <= 1'b1;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            dbl_q    <= 1'b0;
            held_q   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rpt_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ms_cnt_q <= ms_cnt_d;
            btn_q    <= btn_in;
            short_q  <= short_d;
            long_q   <= long_d;
            dbl_q    <= dbl_d;
            held_q   <= (state_d == LONG_HELD);
`ifdef BTN_AUTOREPEAT_EN
            rpt_q    <= rpt_d;
`endif
        end
    end

    assign short_press  = short_q;
    assign long_press   = long_q;
    assign double_click = dbl_q;
    assign held         = held_q;
`ifdef BTN_AUTOREPEAT_EN
    assign repeat_pulse = rpt_q;
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder with DIV=10, LONG=8, DBL=4, REPEAT=2 ticks.
module tb_button_event_decoder;

    typedef enum int {EV_SHORT, EV_LONG, EV_DBL, EV_RPT, EV_HON, EV_HOFF} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    logic btn_in;
    logic short_press, long_press, double_click, repeat_pulse, held;
    logic held_prev = 1'b0;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    button_event_decoder #(
        .CLK_HZ    (1000),
        .TICK_HZ   (100),
        .LONG_MS   (8),
        .DBL_MS    (4),
        .REPEAT_MS (2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .btn_in       (btn_in),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_click (double_click),
        .repeat_pulse (repeat_pulse),
        .held         (held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input ev_kind_t k, input int c);
        exp_t e;
        e.kind = k;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic check_evt(input ev_kind_t k);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event got %s at cycle %0d required none", k.name(), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc) begin
                errors++;
                $display("FAIL event got %s at cycle %0d required %s at cycle %0d",
                         k.name(), cyc, e.kind.name(), e.cyc);
            end
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %b required %b", name, act, req);
        end
    endtask

    // Monitor: every observed pulse or held edge must match the next expected event.
    always @(negedge clk) begin
        if (short_press)          check_evt(EV_SHORT);
        if (long_press)           check_evt(EV_LONG);
        if (double_click)         check_evt(EV_DBL);
        if (repeat_pulse)         check_evt(EV_RPT);
        if (held && !held_prev)   check_evt(EV_HON);
        if (!held && held_prev)   check_evt(EV_HOFF);
        held_prev <= held;
    end

    initial begin
        int d;
        reset_n = 1'b0;
        btn_in  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_bit("rst_short",  short_press,  1'b0);
        check_bit("rst_long",   long_press,   1'b0);
        check_bit("rst_dbl",    double_click, 1'b0);
        check_bit("rst_repeat", repeat_pulse, 1'b0);
        check_bit("rst_held",   held,         1'b0);
        wait_cyc(1);

        // Short press: 30 high, release, short 41 cycles after the fall.
        btn_in = 1'b1; wait_cyc(30);
        btn_in = 1'b0; push(EV_SHORT, cyc + 41); wait_cyc(60);

        // Long press: 100 high.
        d = cyc; btn_in = 1'b1;
        push(EV_LONG, d + 81); push(EV_HON, d + 81);
        wait_cyc(100);
        btn_in = 1'b0; push(EV_HOFF, cyc + 1); wait_cyc(60);

        // Long hold of 150 cycles: repeats every 20 cycles when auto-repeat is built in.
        d = cyc; btn_in = 1'b1;
        push(EV_LONG, d + 81); push(EV_HON, d + 81);
`ifdef BTN_AUTOREPEAT_EN
        push(EV_RPT, d + 101); push(EV_RPT, d + 121); push(EV_RPT, d + 141);
`endif
        wait_cyc(150);
        btn_in = 1'b0; push(EV_HOFF, cyc + 1); wait_cyc(60);

        // Double click: 20 high, 15 low, 20 high.
        btn_in = 1'b1; wait_cyc(20);
        btn_in = 1'b0; wait_cyc(15);
        btn_in = 1'b1; push(EV_DBL, cyc + 1); wait_cyc(20);
        btn_in = 1'b0; wait_cyc(60);

        // Boundary: release on the 8th tick, second press on the DBL timeout tick.
        btn_in = 1'b1; wait_cyc(80);
        btn_in = 1'b0; wait_cyc(40);
        btn_in = 1'b1; push(EV_DBL, cyc + 1); wait_cyc(20);
        btn_in = 1'b0; wait_cyc(60);

        // One cycle longer than the boundary: long press fires, then released at once.
        d = cyc; btn_in = 1'b1;
        push(EV_LONG, d + 81); push(EV_HON, d + 81);
        wait_cyc(81);
        btn_in = 1'b0; push(EV_HOFF, cyc + 1); wait_cyc(60);

        // Second press one cycle after DBL timeout: short, then a fresh short.
        btn_in = 1'b1; wait_cyc(30);
        btn_in = 1'b0; push(EV_SHORT, cyc + 41); wait_cyc(41);
        btn_in = 1'b1; wait_cyc(10);
        btn_in = 1'b0; push(EV_SHORT, cyc + 41); wait_cyc(60);

        // Button held through reset: silent until released and pressed again.
        btn_in = 1'b1; reset_n = 1'b0; wait_cyc(3);
        reset_n = 1'b1; wait_cyc(200);
        btn_in = 1'b0; wait_cyc(20);
        btn_in = 1'b1; wait_cyc(30);
        btn_in = 1'b0; push(EV_SHORT, cyc + 41); wait_cyc(60);

        // Reset during WAIT_SECOND discards the pending short press.
        btn_in = 1'b1; wait_cyc(30);
        btn_in = 1'b0; wait_cyc(20);
        reset_n = 1'b0; wait_cyc(2);
        reset_n = 1'b1; wait_cyc(80);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events got %0d outstanding required 0 (next %s at cycle %0d)",
                     exp_q.size(), exp_q[0].kind.name(), exp_q[0].cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
